serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter WIDTH, default 4, data bits per frame (2..16).
REQ-002 Parameter BIT_CYCLES, default 4, clk cycles per serial bit (even, >=4).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 SIN  input  1  serial line, idle high, synchronous to clk.
REQ-006 msb_first  input  1  0: first data bit is O[0]; 1: first data bit is O[WIDTH-1]; sampled at start-bit confirmation, held for the frame.
REQ-007 ack  input  1  consumer accepts O when high with valid.
REQ-008 O  output  WIDTH  received parallel word.
REQ-009 valid  output  1  O holds an unaccepted word.
REQ-010 busy  output  1  frame in progress (any state but IDLE).
REQ-011 frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-012 overrun  output  1  one-cycle pulse, good frame dropped because valid was high.
REQ-013 parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE -> START on SIN=0; counter loads BIT_CYCLES/2-1.
REQ-016 START mid-bit sample: SIN=0 -> DATA, counter BIT_CYCLES-1; SIN=1 -> IDLE (false start, no flags).
REQ-017 DATA SHALL sample SIN every BIT_CYCLES cycles at mid-bit, shifting into a WIDTH-bit register per msb_first; after WIDTH samples -> PARITY (macro defined) or STOP.
REQ-018 PARITY samples one bit, then -> STOP.
REQ-019 STOP sample 1 with no error: word is good; -> IDLE same cycle.
REQ-020 STOP sample 0: frame_err pulses, word discarded, -> BREAK; BREAK -> IDLE on first cycle SIN=1.
REQ-021 Good word with valid=0, or valid=1 and ack=1 same cycle: O loads the word and valid=1 on the cycle after the stop-bit sample.
REQ-022 Good word with valid=1 and ack=0: O and valid unchanged, overrun pulses on the cycle after the stop-bit sample.
REQ-023 ack with valid=1 and no word completing: valid clears next cycle, O holds its value.
REQ-024 ack with valid=0 SHALL be ignored.
REQ-025 A new start bit SHALL be accepted the cycle after returning to IDLE, regardless of valid.
REQ-026 Stop-bit-sample-to-valid latency SHALL be exactly 1 cycle; start edge to valid = (BIT_CYCLES/2)+(WIDTH+1+P)*BIT_CYCLES+1 cycles, P=1 with parity else 0.

Reset
REQ-027 reset SHALL force IDLE immediately, counters and shift register 0, O=0, valid=0, busy=0, all error pulses 0.
REQ-028 Reset mid-frame discards the partial word; after release the block waits for a fresh SIN=0 in IDLE.

Configuration
REQ-029 Macro SERIAL_FRAME_RX_PARITY_EN defined: frame carries one even-parity bit after data; XOR of data and parity bits =1 -> parity_err pulses with the stop-bit sample, word discarded, valid unchanged.
REQ-030 Macro undefined: PARITY state unreachable, no parity bit expected, parity_err tied 0.

Verification (WIDTH=4, BIT_CYCLES=4, macro undefined unless stated)
REQ-031 msb_first=0, frame 0,1,1,0,1,1 (start, data LSB-first, stop) -> O=4'hB, valid=1, 23 cycles after start edge; ack -> valid=0 next cycle.
REQ-032 msb_first=1, same bit sequence -> O=4'hD, valid=1.
REQ-033 SIN low for 1 cycle then high -> START aborts, busy returns 0, no valid, no flags.
REQ-034 Frame 4'h5 with stop bit 0 -> frame_err single pulse, valid=0, busy stays 1 until SIN=1.
REQ-035 Two good frames 4'h3 then 4'hC, no ack -> O=4'h3 kept, overrun pulse; repeat with ack asserted on second completion cycle -> O=4'hC, no overrun.
REQ-036 Macro defined, data 4'h7 with parity 0 -> parity_err pulse, no valid; parity 1 -> O=4'h7. Reset asserted mid-DATA -> all outputs 0 at once, next full frame received correctly.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity bit, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to expect and check an even-parity bit after the data.
module serial_frame_rx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SIN,
    input  logic             msb_first,
    input  logic             ack,
    output logic [WIDTH-1:0] O,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);
    localparam int unsigned   CW        = $clog2(BIT_CYCLES);
    localparam int unsigned   BW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit            PAR_EN    = 1'b1;
`else
    localparam bit            PAR_EN    = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             msb_q, msb_n;
    logic             par_q, par_n;
    logic             done_q, done_n;
    logic             ferr_n, perr_n, ovr_n, valid_n;
    logic [WIDTH-1:0] o_n;
    logic             tick;
    logic             par_bad;

    assign tick    = (cnt == '0);
    assign par_bad = PAR_EN && par_q;

    // Next-state, bit sampling and output-word handoff
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        msb_n    = msb_q;
        par_n    = par_q;
        done_n   = 1'b0;
        ferr_n   = 1'b0;
        perr_n   = 1'b0;
        ovr_n    = 1'b0;
        o_n      = O;
        valid_n  = valid;

        case (state)
            IDLE: begin
                if (!SIN) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (!SIN) begin
                    state_n  = DATA;
                    cnt_n    = FULL_LOAD;
                    bitcnt_n = '0;
                    msb_n    = msb_first;
                    par_n    = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n   = FULL_LOAD;
                    par_n   = par_q ^ SIN;
                    shreg_n = msb_q ? {shreg[WIDTH-2:0], SIN} : {SIN, shreg[WIDTH-1:1]};
                    if (bitcnt == LAST_BIT) begin
                        bitcnt_n = '0;
                        state_n  = PAR_EN ? PARITY : STOP;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n   = FULL_LOAD;
                    par_n   = par_q ^ SIN;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (!SIN) begin
                    ferr_n  = 1'b1;
                    state_n = BREAK;
                end else begin
                    done_n  = !par_bad;
                    perr_n  = par_bad;
                    state_n = IDLE;
                end
            end
            BREAK: begin
                if (SIN) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A completed word lands one cycle after the stop sample; ack in that cycle frees the slot
        if (valid && ack) valid_n = 1'b0;
        if (done_q) begin
            if (!valid || ack) begin
                o_n     = shreg;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            msb_q      <= 1'b0;
            par_q      <= 1'b0;
            done_q     <= 1'b0;
            O          <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            msb_q      <= msb_n;
            par_q      <= par_n;
            done_q     <= done_n;
            O          <= o_n;
            valid      <= valid_n;
            busy       <= (state_n != IDLE);
            frame_err  <= ferr_n;
            overrun    <= ovr_n;
            parity_err <= perr_n;
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames, expected outcomes queued per frame and
// checked cycle-exactly by a monitor; honours SERIAL_FRAME_RX_PARITY_EN.
module tb_serial_frame_rx;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned BC    = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    // Edges from the first edge that sees the start bit to the stop-bit sample, plus one
    localparam int unsigned LAT = BC / 2 + (WIDTH + 1 + P) * BC + 1;

    logic             clk = 1'b0;
    logic             reset, SIN, msb_first, ack;
    logic [WIDTH-1:0] O;
    logic             valid, busy, frame_err, overrun, parity_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] o;
        logic             valid;
        logic             ovr;
        logic             ferr;
        logic             perr;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    exp_t             cur;
    logic [WIDTH-1:0] model_o;
    logic             model_valid;
    logic             vprev = 1'b0;

    serial_frame_rx #(.WIDTH(WIDTH), .BIT_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .SIN(SIN), .msb_first(msb_first), .ack(ack),
        .O(O), .valid(valid), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    task automatic push(input string tag, input int c, input logic [WIDTH-1:0] o,
                        input logic v, input logic ovr, input logic ferr, input logic perr);
        exp_t e;
        e.tag = tag; e.cyc = c; e.o = o; e.valid = v; e.ovr = ovr; e.ferr = ferr; e.perr = perr;
        sb.push_back(e);
    endtask

    // bits[0] goes on the line first; called just after a rising edge
    task automatic send_frame(input string tag, input logic [WIDTH-1:0] bits, input logic msb,
                              input logic stop, input logic par_ok, input logic ack_end);
        int               c;
        logic [WIDTH-1:0] word;
        logic             pbit;
        word      = msb ? rev(bits) : bits;
        pbit      = (^bits) ^ ~par_ok;
        msb_first = msb;
        c         = cyc;
        if (!stop)
            push(tag, c + LAT, model_o, model_valid, 1'b0, 1'b1, 1'b0);
        else if (P == 1 && !par_ok)
            push(tag, c + LAT, model_o, model_valid, 1'b0, 1'b0, 1'b1);
        else if (model_valid && !ack_end)
            push(tag, c + LAT + 1, model_o, 1'b1, 1'b1, 1'b0, 1'b0);
        else begin
            model_o     = word;
            model_valid = 1'b1;
            push(tag, c + LAT + 1, word, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        SIN = 1'b0;
        repeat (BC) @(posedge clk);
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            SIN = bits[i];
            repeat (BC) @(posedge clk);
            #1;
        end
        if (P == 1) begin
            SIN = pbit;
            repeat (BC) @(posedge clk);
            #1;
        end
        SIN = stop;
        repeat (BC - 1) @(posedge clk);
        #1;
        if (ack_end) ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        if (stop) SIN = 1'b1;
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        model_valid = 1'b0;
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".O"}, 32'(O), 32'(model_o));
    endtask

    // Cycle-exact scoreboard; every other cycle must be free of pulses and of a fresh valid
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            cur = sb.pop_front();
            chk({cur.tag, ".O"}, 32'(O), 32'(cur.o));
            chk({cur.tag, ".valid"}, 32'(valid), 32'(cur.valid));
            chk({cur.tag, ".overrun"}, 32'(overrun), 32'(cur.ovr));
            chk({cur.tag, ".frame_err"}, 32'(frame_err), 32'(cur.ferr));
            chk({cur.tag, ".parity_err"}, 32'(parity_err), 32'(cur.perr));
        end else begin
            chk("idle_pulses", 32'({overrun, frame_err, parity_err}), 32'd0);
            chk("unexpected_valid", 32'(valid & ~vprev), 32'd0);
        end
        vprev = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cyc=%0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; SIN = 1'b1; msb_first = 1'b0; ack = 1'b0;
        model_o = '0; model_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.O", 32'(O), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.flags", 32'({frame_err, overrun, parity_err}), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_frame("f_B", 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("f_B.word", 32'(O), 32'hB);
        repeat (2) @(posedge clk);
        #1;
        do_ack("ack_B");
        do_ack("ack_idle");

        send_frame("f_D", 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("f_D.word", 32'(O), 32'hD);
        do_ack("ack_D");

        // Glitch: one low cycle must abort in START
        SIN = 1'b0;
        @(posedge clk);
        #1;
        chk("glitch.busy_hi", 32'(busy), 32'd1);
        SIN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch.busy_lo", 32'(busy), 32'd0);
        chk("glitch.valid", 32'(valid), 32'd0);

        // Bad stop bit, line held low afterwards
        send_frame("f_5_ferr", 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("break.busy", 32'(busy), 32'd1);
        chk("break.valid", 32'(valid), 32'd0);
        SIN = 1'b1;
        @(posedge clk);
        #1;
        chk("break.exit", 32'(busy), 32'd0);

        send_frame("f_3", 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame("f_C_ovr", 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovr.keep", 32'(O), 32'h3);
        do_ack("ack_3");
        send_frame("f_3b", 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame("f_C_ack", 4'b1100, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ackload.word", 32'(O), 32'hC);
        chk("ackload.valid", 32'(valid), 32'd1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame("f_7_perr", 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("perr.keep", 32'(O), 32'hC);
        do_ack("ack_C");
        send_frame("f_7", 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("par.word", 32'(O), 32'h7);
`endif

        // Reset in the middle of the data bits, with a word still held
        SIN = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        SIN = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst.O", 32'(O), 32'd0);
        chk("midrst.valid", 32'(valid), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.flags", 32'({frame_err, overrun, parity_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_o = '0;
        model_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst.busy", 32'(busy), 32'd0);
        send_frame("f_9", 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("f_9.word", 32'(O), 32'h9);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
